// File: rtl/gecikmeli_bellek_if.sv
// Request/response bundle between the processor memory port (master) and a memory responder (slave).
interface gecikmeli_bellek_if #(
    parameter int ADRES_BIT = 32,
    parameter int VERI_BIT  = 32
);
    logic                 istek_gecerli;
    logic [ADRES_BIT-1:0] adres;
    logic                 yaz_gecerli;
    logic [VERI_BIT-1:0]  yaz_veri;
    logic [VERI_BIT-1:0]  oku_veri;
    logic                 hazir;
    logic                 hata;

    modport master (
        output istek_gecerli, adres, yaz_gecerli, yaz_veri,
        input  oku_veri, hazir, hata
    );

    modport slave (
        input  istek_gecerli, adres, yaz_gecerli, yaz_veri,
        output oku_veri, hazir, hata
    );
endinterface

// File: rtl/gecikmeli_bellek.sv
// Word-addressed RAM responder with GECIKME wait states per access; optional LFSR-added
// jitter of 0..3 extra wait cycles when GECIKME_RASTGELE_EN is defined.
//
// state | meaning
// BOSTA | idle, accepts a held request
// BEKLE | counting wait states on the captured request
// YANIT | one-cycle hazir pulse, never accepts
module gecikmeli_bellek #(
    parameter int                   ADRES_BIT    = 32,
    parameter logic [ADRES_BIT-1:0] BELLEK_ADRES = 32'h8000_0000,
    parameter int                   VERI_BIT     = 32,
    parameter int                   BELLEK_SATIR = 1024,
    parameter int                   GECIKME      = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    gecikmeli_bellek_if.slave      bus
);
    localparam int SATIR_BIT = $clog2(BELLEK_SATIR);
    localparam logic [ADRES_BIT:0] UST_SINIR = (ADRES_BIT + 1)'(4 * BELLEK_SATIR);

    typedef enum logic [1:0] {BOSTA, BEKLE, YANIT} durum_t;

    durum_t                r_durum;
    durum_t                w_sonraki;
    logic [4:0]            r_sayac;
    logic                  r_yaz;
    logic [ADRES_BIT-1:0]  r_adres;
    logic [VERI_BIT-1:0]   r_yaz_veri;
    logic [VERI_BIT-1:0]   r_oku_veri;
    logic                  r_hata;

    logic [VERI_BIT-1:0]   bellek [BELLEK_SATIR];

    logic [ADRES_BIT-1:0]  w_ofset;
    logic                  w_aralik;
    logic [SATIR_BIT-1:0]  w_satir;
    logic                  w_kabul;
    logic                  w_bitir;
    logic [4:0]            w_yukle;
    logic                  w_hazir;

    // Unsigned wrap of the subtraction folds both range bounds into a single compare.
    assign w_ofset  = r_adres - BELLEK_ADRES;
    assign w_aralik = ({1'b0, w_ofset} < UST_SINIR);
    assign w_satir  = w_ofset[SATIR_BIT+1:2];
    assign w_kabul  = (r_durum == BOSTA) && bus.istek_gecerli;
    assign w_bitir  = (r_durum == BEKLE) && bus.istek_gecerli && (r_sayac == 5'd0);

`ifdef GECIKME_RASTGELE_EN
    logic [7:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= 8'hA5;
        end else if (w_kabul) begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end

    assign w_yukle = 5'(GECIKME) + {3'b000, r_lfsr[1:0]};
`else
    assign w_yukle = 5'(GECIKME);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_durum <= BOSTA;
        end else begin
            r_durum <= w_sonraki;
        end
    end

    always_comb begin
        w_sonraki = r_durum;
        case (r_durum)
            BOSTA: if (bus.istek_gecerli) w_sonraki = BEKLE;
            BEKLE: begin
                if (!bus.istek_gecerli) begin
                    w_sonraki = BOSTA;
                end else if (r_sayac == 5'd0) begin
                    w_sonraki = YANIT;
                end
            end
            YANIT:   w_sonraki = BOSTA;
            default: w_sonraki = BOSTA;
        endcase
    end

    always_comb begin
        w_hazir = 1'b0;
        if (r_durum == YANIT) begin
            w_hazir = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_kabul) begin
            r_yaz      <= bus.yaz_gecerli;
            r_adres    <= bus.adres;
            r_yaz_veri <= bus.yaz_veri;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sayac    <= 5'd0;
            r_oku_veri <= '0;
            r_hata     <= 1'b0;
        end else begin
            if (w_kabul) begin
                r_sayac <= w_yukle;
            end else if ((r_durum == BEKLE) && (r_sayac != 5'd0)) begin
                r_sayac <= r_sayac - 5'd1;
            end
            if (w_bitir) begin
                if (r_yaz) begin
                    r_oku_veri <= r_yaz_veri;
                end else if (w_aralik) begin
                    r_oku_veri <= bellek[w_satir];
                end else begin
                    r_oku_veri <= '0;
                end
                if (!w_aralik) begin
                    r_hata <= 1'b1;
                end
            end
        end
    end

    // Plain always so benches can preload bellek through a hierarchical reference.
    always @(posedge clk) begin
        if (!rst && w_bitir && r_yaz && w_aralik) begin
            bellek[w_satir] <= r_yaz_veri;
        end
    end

    assign bus.hazir    = w_hazir;
    assign bus.oku_veri = r_oku_veri;
    assign bus.hata     = r_hata;
endmodule

// File: doc/gecikmeli_bellek.md
Name: gecikmeli_bellek

Overview:
- Memory-side responder for the processor memory port, with a configurable number of wait states.
- Word-addressed RAM mapped at BELLEK_ADRES.
- The initiator (islemci) holds a request until `hazir` pulses. This lets the processor's stall path (`ilerle_cmb` held low) be exercised against a memory with non-zero latency.
- Drop-in replacement for the zero-latency main memory in stall benches.

Parameters:
- BELLEK_ADRES, 32'h8000_0000, byte address of row 0.
- ADRES_BIT, 32, address width.
- VERI_BIT, 32, data width (row width).
- BELLEK_SATIR, 1024, number of rows.
- GECIKME, 2, fixed wait cycles per access (0..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- istek_gecerli  in  1  request valid, held by initiator until hazir.
- adres  in  ADRES_BIT  byte address; bits [1:0] ignored.
- yaz_gecerli  in  1  1 = write request, 0 = read request.
- yaz_veri  in  VERI_BIT  write data.
- oku_veri  out  VERI_BIT  response data, valid while hazir=1.
- hazir  out  1  one-cycle response pulse.
- hata  out  1  sticky out-of-range flag.

Behaviour:
- Reset (sync, active-high): state=BOSTA, hazir=0, oku_veri=0, hata=0, counter=0. RAM contents are not cleared. Reset during BEKLE aborts the access; no write is committed.
- Row index = (adres - BELLEK_ADRES) >> 2. The address is in range iff BELLEK_ADRES <= adres < BELLEK_ADRES + 4*BELLEK_SATIR (unsigned compare).
- The `bellek` array must be hierarchically accessible so benches can preload it.
- FSM states: BOSTA, BEKLE, YANIT.
- BOSTA:
  - If istek_gecerli=1 at an edge, capture adres/yaz_gecerli/yaz_veri, load counter=GECIKME, go to BEKLE.
  - Otherwise stay.
- BEKLE:
  - If istek_gecerli=0 at an edge, abort: go to BOSTA, no write, no hazir.
  - Else if counter!=0, decrement.
  - Else (counter==0) go to YANIT and, at this same edge:
    - Write: RAM[row] <= captured yaz_veri if in range; oku_veri <= captured yaz_veri.
    - Read: oku_veri <= RAM[row] if in range, else 0.
    - Out of range: hata <= 1 (write dropped).
    - hazir <= 1.
- YANIT: hazir=1 for exactly this cycle. Next edge: hazir <= 0, go to BOSTA. A request is never accepted in YANIT.
- Latency and throughput:
  - hazir is high in the cycle following the (GECIKME+2)th edge after the acceptance edge; acceptance edge counts as edge 1.
  - Equivalently, GECIKME+1 full cycles of wait between the acceptance cycle and the hazir cycle.
  - Back-to-back throughput: one access per GECIKME+3 cycles.
- oku_veri holds its last value after hazir falls.
- Inputs changing during BEKLE (other than istek_gecerli) are a protocol violation; captured values are used.
- hata clears only on rst.

Optional Feature:
- Macro: GECIKME_RASTGELE_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4) with seed 8'hA5 on reset advances once per accepted request.
  - Counter load = GECIKME + lfsr[1:0], which adds 0..3 wait cycles.
  - The sequence is deterministic after reset.
- Undefined: LFSR absent; latency is fixed at GECIKME.

Test Plan:
- Preload row 0 = 32'h00408ab3; read request at 32'h8000_0000 with GECIKME=2 held high → hazir pulses once, exactly 4 cycles after the acceptance cycle; oku_veri=32'h00408ab3; hata=0.
- Write 32'hdeadbeef to 32'h8000_0010, then read the same address → write response oku_veri=32'hdeadbeef; read returns 32'hdeadbeef; bellek[4]=32'hdeadbeef.
- Read at 32'h8000_1000 (BELLEK_SATIR=1024), then write 32'h1 to 32'h7fff_fffc → both hazir pulses occur; read oku_veri=0; no RAM row changes; hata=1 and stays 1 until rst.
- Write to 32'h8000_0008 with istek_gecerli dropped after 1 cycle → no hazir; bellek[2] unchanged. Same test with rst asserted mid-BEKLE → no write; hazir=0; state BOSTA.
- Two back-to-back reads with istek_gecerli held continuously, GECIKME=0 → hazir pulses 3 cycles apart; request not re-accepted in the YANIT cycle; correct data for each.
- GECIKME_RASTGELE_EN defined, 8 sequential reads → per-access latencies match the reference LFSR model from seed 8'hA5; all data correct.
